seg_scan_driver: RTL and testbench

- Multi-digit, time-multiplexed 7-segment display driver; successor to the single-digit nibble-to-segment decoder.
- Holds a shadow register of NUM_DIGITS nibble codes plus per-digit blank, blink and decimal-point masks.
- Scans one digit per slot and adds a dead-time gap between digits, leading-zero blanking and blinking.
- Sits between display-formatting logic and the board's segment/anode pins.

---
 rtl/seg_scan_driver_if.sv | 19 +
 rtl/seg_scan_driver.sv | 131 +++++++++++++
 tb/tb_seg_scan_driver.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_driver_if.sv
// rtl/seg_scan_driver_if.sv - shadow-register load bus for the segment scan driver
interface seg_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic                    lz_en;

    modport master (
        output load, digits_in, blank_mask, blink_mask, dp_mask, lz_en
    );

    modport slave (
        input  load, digits_in, blank_mask, blink_mask, dp_mask, lz_en
    );
endinterface

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - time-multiplexed multi-digit 7-segment scan driver
module seg_scan_driver #(
    parameter int NUM_DIGITS    = 8,
    parameter int SCAN_DIV      = 100000,
    parameter int DEAD_CYC      = 1000,
    parameter int BLINK_DIV     = 50,
    parameter bit AN_ACTIVE_LOW = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    seg_scan_driver_if.slave              bus,
    output logic [7:0]                    seg_out,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
    output logic                          frame_start
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0]         CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]         DEAD_END = CW'(DEAD_CYC);
    localparam logic [IW-1:0]         IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0]         FRM_LAST = FW'(BLINK_DIV - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{AN_ACTIVE_LOW}};

    logic [CW-1:0]           cnt;
    logic [FW-1:0]           frame_cnt;
    logic                    blink_phase;
    logic [4*NUM_DIGITS-1:0] sh_digits;
    logic [NUM_DIGITS-1:0]   sh_blank;
    logic [NUM_DIGITS-1:0]   sh_blink;
    logic [NUM_DIGITS-1:0]   sh_dp;
    logic                    sh_lz;

    logic [3:0]              code;
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [7:0]              seg_next;
    logic [NUM_DIGITS-1:0]   an_next;
    logic                    slot_end;
    logic                    wrap;

    function automatic logic [7:0] glyph(input logic [3:0] c);
        case (c)
            4'h0:    glyph = 8'hFC;
            4'h1:    glyph = 8'h60;
            4'h2:    glyph = 8'hDA;
            4'h3:    glyph = 8'hF2;
            4'h4:    glyph = 8'h66;
            4'h5:    glyph = 8'hB6;
            4'h6:    glyph = 8'hBE;
            4'h7:    glyph = 8'hE0;
            4'h8:    glyph = 8'hFE;
            4'h9:    glyph = 8'hE6;
            4'hA:    glyph = 8'h02;
            default: glyph = 8'h00;
        endcase
    endfunction

    assign slot_end = (cnt == CNT_LAST);
    assign wrap     = slot_end && (scan_idx == IDX_LAST);
    assign code     = sh_digits[{scan_idx, 2'b00} +: 4];

    // Walk down from the most significant digit; the run of zeros ends at the first non-zero code.
    always_comb begin : lz_scan
        logic run;
        lz_blank = '0;
        run      = sh_lz;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            run         = run && (sh_digits[4*k +: 4] == 4'h0);
            lz_blank[k] = run;
        end
    end

    always_comb begin
        seg_next = 8'h00;
        an_next  = '0;
        if (cnt >= DEAD_END) begin
            an_next  = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << scan_idx;
            seg_next = glyph(code) | {7'b0, sh_dp[scan_idx]};
            if (sh_blank[scan_idx] || lz_blank[scan_idx] ||
                (sh_blink[scan_idx] && !blink_phase)) begin
                seg_next = 8'h00;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            scan_idx    <= '0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            blink_phase <= 1'b1;
            seg_out     <= 8'h00;
            an          <= AN_OFF;
        end else begin
            cnt         <= slot_end ? '0 : cnt + 1'b1;
            frame_start <= wrap;
            if (slot_end) begin
                scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
            end
            // Counting the registered pulse lands the blink toggle in digit 0's dead time.
            if (frame_start) begin
                if (frame_cnt == FRM_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
            seg_out <= seg_next;
            an      <= an_next ^ AN_OFF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_digits <= {NUM_DIGITS{4'hB}};
            sh_blank  <= '0;
            sh_blink  <= '0;
            sh_dp     <= '0;
            sh_lz     <= 1'b0;
        end else if (bus.load) begin
            sh_digits <= bus.digits_in;
            sh_blank  <= bus.blank_mask;
            sh_blink  <= bus.blink_mask;
            sh_dp     <= bus.dp_mask;
            sh_lz     <= bus.lz_en;
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - self-checking bench for seg_scan_driver
`timescale 1ns/1ps
module tb_seg_scan_driver;
    localparam int N  = 4;
    localparam int SD = 4;
    localparam int DC = 1;
    localparam int BD = 2;
    localparam logic [7:0] GLYPH [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                          8'hFE, 8'hE6, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   seg_out;
    logic [N-1:0] an;
    logic [1:0]   scan_idx;
    logic         frame_start;

    seg_scan_driver_if #(.NUM_DIGITS(N)) ifc();

    seg_scan_driver #(
        .NUM_DIGITS(N), .SCAN_DIV(SD), .DEAD_CYC(DC), .BLINK_DIV(BD), .AN_ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .bus(ifc),
        .seg_out(seg_out), .an(an), .scan_idx(scan_idx), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int t     = 0;

    logic [15:0] m_dig;
    logic [3:0]  m_blank, m_blink, m_dp;
    logic        m_lz;
    logic [7:0]  exp_seg;
    logic [3:0]  exp_an;
    logic [1:0]  exp_idx;
    logic        exp_fs;

    // Display for the scan position tt cycles after reset release, from the shadow contents.
    function automatic logic [7:0] model_seg(int tt);
        int         cnt, idx, pulses;
        bit         visible;
        logic [7:0] s;
        cnt = tt % SD;
        idx = (tt / SD) % N;
        if (cnt < DC) return 8'h00;
        pulses  = (tt >= 1) ? (tt - 1) / (SD * N) : 0;
        visible = ((pulses / BD) % 2) == 0;
        if (m_blank[idx]) return 8'h00;
        if (m_blink[idx] && !visible) return 8'h00;
        if (m_lz && idx > 0 && (m_dig >> (4 * idx)) == 16'h0) return 8'h00;
        s    = GLYPH[m_dig[4*idx +: 4]];
        s[0] = m_dp[idx];
        return s;
    endfunction

    function automatic logic [3:0] model_an(int tt);
        if ((tt % SD) < DC) return 4'b0000;
        return 4'b0001 << ((tt / SD) % N);
    endfunction

    task automatic cycle();
        @(posedge clk);
        if (rst) begin
            t = 0;
            m_dig = 16'hBBBB; m_blank = '0; m_blink = '0; m_dp = '0; m_lz = 1'b0;
            exp_seg = 8'h00; exp_an = 4'b0000; exp_idx = 2'd0; exp_fs = 1'b0;
        end else begin
            exp_seg = model_seg(t);
            exp_an  = model_an(t);
            if (ifc.load) begin
                m_dig = ifc.digits_in; m_blank = ifc.blank_mask; m_blink = ifc.blink_mask;
                m_dp = ifc.dp_mask; m_lz = ifc.lz_en;
            end
            t++;
            exp_idx = 2'((t / SD) % N);
            exp_fs  = (t % (SD * N)) == 0;
        end
        @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] bl, input logic [3:0] bk,
                           input logic [3:0] dp, input logic lz);
        ifc.digits_in = d; ifc.blank_mask = bl; ifc.blink_mask = bk; ifc.dp_mask = dp;
        ifc.lz_en = lz; ifc.load = 1'b1;
        cycle();
        ifc.load = 1'b0;
    endtask

    task automatic test_reset();
        int nfs;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            tests++;
            if (seg_out !== 8'h00 || an !== 4'b0000 || scan_idx !== 2'd0 || frame_start !== 1'b0) begin
                fails++;
                $display("FAIL reset_hold seg=%h an=%b idx=%0d fs=%b, want 00 0000 0 0",
                         seg_out, an, scan_idx, frame_start);
            end
        end
        rst = 1'b0;
        nfs = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (frame_start === 1'b1) nfs++;
            tests++;
            if (seg_out !== 8'h00) begin
                fails++; $display("FAIL reset_seg t=%0d got %h want 00", t, seg_out);
            end
            tests++;
            if (an !== exp_an) begin
                fails++; $display("FAIL reset_an t=%0d got %b want %b", t, an, exp_an);
            end
            tests++;
            if (scan_idx !== exp_idx) begin
                fails++; $display("FAIL reset_idx t=%0d got %0d want %0d", t, scan_idx, exp_idx);
            end
            tests++;
            if (frame_start !== exp_fs) begin
                fails++; $display("FAIL reset_fs t=%0d got %b want %b", t, frame_start, exp_fs);
            end
        end
        tests++;
        if (nfs != 2) begin
            fails++; $display("FAIL reset_fs_count got %0d want 2", nfs);
        end
    endtask

    task automatic test_pattern(input string name, input logic [15:0] d, input logic [3:0] dp,
                                input logic lz, input logic [7:0] w0, input logic [7:0] w1,
                                input logic [7:0] w2, input logic [7:0] w3);
        logic [7:0] want [4];
        int slot;
        want = '{w0, w1, w2, w3};
        do_load(d, 4'b0000, 4'b0000, dp, lz);
        for (int i = 0; i < 20; i++) begin
            cycle();
            tests++;
            if (seg_out !== exp_seg || an !== exp_an) begin
                fails++;
                $display("FAIL %s_model t=%0d seg=%h an=%b want %h %b", name, t, seg_out, an, exp_seg, exp_an);
            end
            if (((t - 1) % SD) == 2) begin
                slot = ((t - 1) / SD) % N;
                tests++;
                if (seg_out !== want[slot] || an !== (4'b0001 << slot)) begin
                    fails++;
                    $display("FAIL %s_slot%0d seg=%h an=%b want %h %b", name, slot, seg_out, an,
                             want[slot], 4'b0001 << slot);
                end
            end
        end
    endtask

    task automatic test_blink();
        int lit, dark;
        lit = 0; dark = 0;
        do_load(16'h1234, 4'b0000, 4'b0001, 4'b0000, 1'b0);
        for (int i = 0; i < 128; i++) begin
            cycle();
            if (((t - 1) % SD) == 2 && ((t - 1) / SD) % N == 0) begin
                if (seg_out === 8'h66) lit++;
                if (seg_out === 8'h00) dark++;
            end
            tests++;
            if (seg_out !== exp_seg || an !== exp_an) begin
                fails++;
                $display("FAIL blink t=%0d seg=%h an=%b want %h %b", t, seg_out, an, exp_seg, exp_an);
            end
        end
        tests++;
        if (lit != 4 || dark != 4) begin
            fails++; $display("FAIL blink_ratio lit=%0d dark=%0d want 4 4", lit, dark);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            ifc.load = ($urandom_range(0, 5) == 0);
            if (ifc.load) begin
                for (int k = 0; k < N; k++)
                    ifc.digits_in[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                ifc.blank_mask = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
                ifc.blink_mask = 4'($urandom);
                ifc.dp_mask    = 4'($urandom);
                ifc.lz_en      = 1'($urandom);
            end
            cycle();
            tests++;
            if (seg_out !== exp_seg || an !== exp_an || scan_idx !== exp_idx || frame_start !== exp_fs) begin
                fails++;
                $display("FAIL random t=%0d seg=%h an=%b idx=%0d fs=%b want %h %b %0d %b",
                         t, seg_out, an, scan_idx, frame_start, exp_seg, exp_an, exp_idx, exp_fs);
            end
        end
        ifc.load = 1'b0;
    endtask

    task automatic test_mid_load();
        logic [3:0] an_before;
        bit found;
        do_load(16'h5555, 4'b0000, 4'b0000, 4'b0000, 1'b0);
        found = 0;
        for (int i = 0; i < 2 * SD && !found; i++) begin
            if ((t % SD) == 2) found = 1; else cycle();
        end
        tests++;
        if (!found) begin
            fails++; $display("FAIL midload_align got no slot midpoint want one within %0d cycles", 2 * SD);
        end
        an_before = an;
        do_load(16'h8888, 4'b0000, 4'b0000, 4'b1111, 1'b0);
        tests++;
        if (seg_out !== exp_seg || an !== an_before) begin
            fails++; $display("FAIL midload_edge seg=%h an=%b want %h %b", seg_out, an, exp_seg, an_before);
        end
        cycle();
        tests++;
        if (seg_out !== 8'hFF || an !== an_before || an !== exp_an) begin
            fails++; $display("FAIL midload_next seg=%h an=%b want ff %b", seg_out, an, an_before);
        end
    endtask

    task automatic test_mid_reset();
        bit found;
        found = 0;
        for (int i = 0; i < 2 * SD * N && !found; i++) begin
            if (((t / SD) % N) == 2 && (t % SD) == 2) found = 1; else cycle();
        end
        tests++;
        if (!found) begin
            fails++; $display("FAIL midrst_align got no slot 2 midpoint want one within %0d cycles", 2 * SD * N);
        end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        tests++;
        if (seg_out !== 8'h00 || an !== 4'b0000 || scan_idx !== 2'd0 || frame_start !== 1'b0) begin
            fails++;
            $display("FAIL midrst_out seg=%h an=%b idx=%0d fs=%b want 00 0000 0 0", seg_out, an, scan_idx, frame_start);
        end
        for (int i = 0; i < 20; i++) begin
            cycle();
            tests++;
            if (seg_out !== 8'h00 || an !== exp_an || scan_idx !== exp_idx) begin
                fails++;
                $display("FAIL midrst_scan t=%0d seg=%h an=%b idx=%0d want 00 %b %0d", t, seg_out, an, scan_idx, exp_an, exp_idx);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        ifc.load = 1'b0; ifc.digits_in = '0; ifc.blank_mask = '0;
        ifc.blink_mask = '0; ifc.dp_mask = '0; ifc.lz_en = 1'b0;
        test_reset();
        test_pattern("decode", 16'h1234, 4'b0000, 1'b0, 8'h66, 8'hF2, 8'hDA, 8'h60);
        test_pattern("lz_0070", 16'h0070, 4'b0000, 1'b1, 8'hFC, 8'hE0, 8'h00, 8'h00);
        test_pattern("lz_0000", 16'h0000, 4'b0000, 1'b1, 8'hFC, 8'h00, 8'h00, 8'h00);
        test_pattern("dp_minus", 16'hBA05, 4'b0010, 1'b0, 8'hB6, 8'hFD, 8'h02, 8'h00);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        test_blink();
        test_random();
        test_mid_load();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
